// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// State encoding is fixed at IDLE=0, SHIFT=1, DONE=2.
package serial_adder_pkg;

  localparam int SA_DEFAULT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder cell used as the per-bit
// datapath of serial_adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial W-bit adder, LSB first, valid/ready in and out.
// Define SERIAL_ADDER_SUB_EN to add a 'sub' port for a-b.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int W = SA_DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic         sub,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int CW = $clog2(W) + 1;

  state_e          state;
  logic [W-1:0]    a_sr;
  logic [W-1:0]    b_sr;
  logic [W-1:0]    sum_r;
  logic [W-1:0]    sum_nx;
  logic [CW-1:0]   cnt;
  logic            carry;
  logic            cout_r;
  logic            fa_b;
  logic            fa_s;
  logic            fa_co;
  logic            last;

`ifdef SERIAL_ADDER_SUB_EN
  logic            sub_q;
`else
  localparam logic sub_q = 1'b0;
`endif

  // Subtract is add of ~b with carry-in 1.
  assign fa_b = b_sr[0] ^ sub_q;

  full_adder u_fa (
    .a    (a_sr[0]),
    .b    (fa_b),
    .cin  (carry),
    .sum  (fa_s),
    .cout (fa_co)
  );

  assign last = (cnt == CW'(W - 1));

  always_comb begin
    sum_nx        = sum_r >> 1;
    sum_nx[W-1]   = fa_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_r  <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sub_q  <= 1'b0;
`endif
    end else begin
      unique case (1'b1)
        state == IDLE: begin
          if (in_valid) begin
            a_sr  <= a;
            b_sr  <= b;
            cnt   <= '0;
            state <= SHIFT;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q <= sub;
            carry <= sub;
`else
            carry <= 1'b0;
`endif
          end
        end
        state == SHIFT: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          sum_r <= sum_nx;
          carry <= fa_co;
          cnt   <= cnt + 1'b1;
          if (last) begin
            cout_r <= fa_co;
            state  <= DONE;
          end
        end
        state == DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_r;
  assign cout      = cout_r;

endmodule

// File: tb/tb_serial_adder.sv
// Randomised self-checking bench for serial_adder (W=8 and W=1).
// Reference results come from plain integer arithmetic.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, cout, sub;
  logic [7:0] a, b, sum;
  logic       in_valid1, in_ready1, out_valid1, out_ready1, cout1, sub1;
  logic [0:0] a1, b1, sum1;

  int nv = 0;
  int nm = 0;

  always #5 clk = ~clk;

  serial_adder #(.W(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  serial_adder #(.W(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .a         (a1),
    .b         (b1),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub1),
`endif
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .sum       (sum1),
    .cout      (cout1)
  );

  // Reference: unsigned add, or a-b with cout meaning no borrow.
  function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y,
                                       input logic s);
    int r;
    if (s) begin
      r = (int'(x) - int'(y)) & 255;
      return {(x >= y), 8'(r)};
    end
    r = int'(x) + int'(y);
    return 9'(r);
  endfunction

  // Drives one operation into dut8 and waits for out_valid.
  // Returns at a negedge with the result presented.
  task automatic run_op(input logic [7:0] xa, input logic [7:0] xb,
                        input logic xs, output logic [7:0] rs,
                        output logic rc, output int lat);
    int t;
    t = 0;
    in_valid = 1'b1;
    a = xa;
    b = xb;
    sub = xs;
    while (in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    rs = sum;
    rc = cout;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    nv++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      nm++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1 0",
               in_ready, out_valid);
    end
    nv++;
    if (sum !== 8'h00 || cout !== 1'b0) begin
      nm++;
      $display("FAIL reset_out: sum=%h cout=%b want 00 0", sum, cout);
    end
    nv++;
    if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0 ||
        sum1 !== 1'b0 || cout1 !== 1'b0) begin
      nm++;
      $display("FAIL reset_w1: rdy=%b vld=%b sum=%b cout=%b want 1 0 0 0",
               in_ready1, out_valid1, sum1, cout1);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero();
    logic [7:0] rs;
    logic       rc;
    int         lat;
    out_ready = 1'b1;
    run_op(8'h00, 8'h00, 1'b0, rs, rc, lat);
    nv++;
    if (lat != 8) begin
      nm++;
      $display("FAIL zero_latency: got %0d want 8", lat);
    end
    nv++;
    if (rs !== 8'h00 || rc !== 1'b0) begin
      nm++;
      $display("FAIL zero_sum: sum=%h cout=%b want 00 0", rs, rc);
    end
    @(negedge clk);
    nv++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      nm++;
      $display("FAIL zero_return: in_ready=%b out_valid=%b want 1 0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_no_leak();
    logic [7:0] rs;
    logic       rc;
    int         lat;
    out_ready = 1'b1;
    run_op(8'hFF, 8'h01, 1'b0, rs, rc, lat);
    @(negedge clk);
    nv++;
    if (rs !== 8'h00 || rc !== 1'b1) begin
      nm++;
      $display("FAIL carry_out: sum=%h cout=%b want 00 1", rs, rc);
    end
    run_op(8'hA5, 8'h5A, 1'b0, rs, rc, lat);
    @(negedge clk);
    nv++;
    if (rs !== 8'hFF || rc !== 1'b0) begin
      nm++;
      $display("FAIL carry_leak: sum=%h cout=%b want ff 0", rs, rc);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] rs;
    logic       rc;
    int         lat;
    out_ready = 1'b0;
    run_op(8'h80, 8'h80, 1'b0, rs, rc, lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      a = 8'h11;
      b = 8'h22;
      @(negedge clk);
      nv++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          sum !== 8'h00 || cout !== 1'b1) begin
        nm++;
        $display("FAIL hold_%0d: vld=%b rdy=%b sum=%h cout=%b want 1 0 00 1",
                 i, out_valid, in_ready, sum, cout);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    nv++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      nm++;
      $display("FAIL hold_release: rdy=%b vld=%b want 1 0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] rs;
    logic       rc;
    int         lat;
    out_ready = 1'b1;
    in_valid = 1'b1;
    a = 8'hFF;
    b = 8'hFF;
    sub = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    nv++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
        sum !== 8'h00 || cout !== 1'b0) begin
      nm++;
      $display("FAIL mid_reset: rdy=%b vld=%b sum=%h cout=%b want 1 0 00 0",
               in_ready, out_valid, sum, cout);
    end
    run_op(8'h0F, 8'h01, 1'b0, rs, rc, lat);
    @(negedge clk);
    nv++;
    if (rs !== 8'h10 || rc !== 1'b0) begin
      nm++;
      $display("FAIL post_reset: sum=%h cout=%b want 10 0", rs, rc);
    end
  endtask

  task automatic test_sub();
`ifdef SERIAL_ADDER_SUB_EN
    logic [7:0] rs;
    logic       rc;
    int         lat;
    out_ready = 1'b1;
    run_op(8'h10, 8'h01, 1'b1, rs, rc, lat);
    @(negedge clk);
    nv++;
    if (rs !== 8'h0F || rc !== 1'b1) begin
      nm++;
      $display("FAIL sub_noborrow: sum=%h cout=%b want 0f 1", rs, rc);
    end
    run_op(8'h01, 8'h02, 1'b1, rs, rc, lat);
    @(negedge clk);
    nv++;
    if (rs !== 8'hFF || rc !== 1'b0) begin
      nm++;
      $display("FAIL sub_borrow: sum=%h cout=%b want ff 0", rs, rc);
    end
`endif
  endtask

  task automatic test_random();
    logic [7:0] xa, xb, rs;
    logic       xs, rc;
    logic [8:0] exp;
    int         lat, stall;
    for (int i = 0; i < 40; i++) begin
      xa = 8'($urandom);
      xb = 8'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      xs = 1'($urandom);
`else
      xs = 1'b0;
`endif
      stall = $urandom_range(0, 3);
      out_ready = (stall == 0);
      exp = model(xa, xb, xs);
      run_op(xa, xb, xs, rs, rc, lat);
      repeat (stall) @(negedge clk);
      nv++;
      if (rs !== exp[7:0] || rc !== exp[8] || sum !== rs || lat != 8) begin
        nm++;
        $display("FAIL rand_%0d: a=%h b=%h s=%b sum=%h cout=%b lat=%0d want %h %b 8",
                 i, xa, xb, xs, sum, rc, lat, exp[7:0], exp[8]);
      end
      out_ready = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_w1();
    int lat;
    out_ready1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a1 = 1'(i);
      b1 = 1'(i >> 1);
      in_valid1 = 1'b1;
      @(negedge clk);
      in_valid1 = 1'b0;
      lat = 0;
      while (out_valid1 !== 1'b1 && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      nv++;
      if (lat != 1 || sum1 !== 1'(i ^ (i >> 1)) ||
          cout1 !== 1'(i & (i >> 1))) begin
        nm++;
        $display("FAIL w1_%0d: lat=%0d sum=%b cout=%b want 1 %b %b",
                 i, lat, sum1, cout1, 1'(i ^ (i >> 1)), 1'(i & (i >> 1)));
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    sub = 1'b0;
    in_valid1 = 1'b0;
    out_ready1 = 1'b1;
    a1 = '0;
    b1 = '0;
    sub1 = 1'b0;
    @(negedge clk);
    test_reset();
    test_zero();
    test_no_leak();
    test_backpressure();
    test_mid_reset();
    test_sub();
    test_random();
    test_w1();
    $display("== %0d vectors applied, %0d miscompares ==", nv, nm);
    $finish;
  end

endmodule
